// File: rtl/csr_if.sv
// csr_if: bundle between execute stage and the machine-mode CSR file.
// Carries the Zicsr decode inputs, trap/mret controls and the registered CSR views.
interface csr_if #(
   parameter int XLEN = 64
);
   logic            csr_valid;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [11:0]     csr_addr;
   logic [4:0]      zimm;
   logic [XLEN-1:0] src_data;
   logic [XLEN-1:0] rd_data;
   logic            illegal;
   logic            retire;
   logic            trap_valid;
   logic [XLEN-1:0] trap_cause;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] trap_tval;
   logic            mret;
   logic [XLEN-1:0] mtvec_o;
   logic [XLEN-1:0] mepc_o;
   logic            mie_o;
   modport master (
      output csr_valid, opcode, funct3, csr_addr, zimm, src_data, retire,
             trap_valid, trap_cause, trap_pc, trap_tval, mret,
      input  rd_data, illegal, mtvec_o, mepc_o, mie_o
   );
   modport slave (
      input  csr_valid, opcode, funct3, csr_addr, zimm, src_data, retire,
             trap_valid, trap_cause, trap_pc, trap_tval, mret,
      output rd_data, illegal, mtvec_o, mepc_o, mie_o
   );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR file with Zicsr read-modify-write, trap entry and mret.
// Define CSR_COUNTERS_EN to build the mcycle/minstret registers; otherwise they read 0.
module csr_regfile #(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] HART_ID   = '0,
   parameter logic [XLEN-1:0] RESET_VEC = 64'h8000_0000
) (
   input logic   clk,
   input logic   rst,
   csr_if.slave  bus
);
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [11:0] A_MHARTID  = 12'hF14;
   localparam logic [XLEN-1:0] ALIGN  = {{(XLEN-2){1'b1}}, 2'b00};
   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic [XLEN-1:0] mie_csr_q, mie_csr_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [XLEN-1:0] cyc_rd, ins_rd, operand, old_val, new_val;
   logic            is_csr, wr_att, addr_ok, illegal, wr_en;
   logic [11:0]     wa;
   assign is_csr  = bus.csr_valid && bus.opcode == 7'b1110011 && bus.funct3 != 3'b000;
   assign wr_att  = bus.funct3[1:0] == 2'b01 || (bus.funct3[1] && bus.zimm != 5'd0);
   assign operand = bus.funct3[2] ? {{(XLEN-5){1'b0}}, bus.zimm} : bus.src_data;
   assign new_val = bus.funct3[1:0] == 2'b01 ? operand :
                    bus.funct3[1:0] == 2'b10 ? old_val | operand : old_val & ~operand;
   always_comb begin
      addr_ok = 1'b1;
      old_val = '0;
      case (bus.csr_addr)
         A_MSTATUS:  begin old_val[3] = mie_q; old_val[7] = mpie_q; end
         A_MIE:      old_val = mie_csr_q;
         A_MTVEC:    old_val = mtvec_q;
         A_MSCRATCH: old_val = mscratch_q;
         A_MEPC:     old_val = mepc_q;
         A_MCAUSE:   old_val = mcause_q;
         A_MTVAL:    old_val = mtval_q;
         A_MCYCLE:   old_val = cyc_rd;
         A_MINSTRET: old_val = ins_rd;
         A_MHARTID:  old_val = HART_ID;
         default:    addr_ok = 1'b0;
      endcase
   end
   assign illegal     = is_csr && (!addr_ok || (&bus.csr_addr[11:10] && wr_att));
   assign wr_en       = is_csr && !illegal && wr_att && !bus.trap_valid;
   // 0x000 is never implemented, so it doubles as "no write this cycle"
   assign wa          = wr_en ? bus.csr_addr : 12'h000;
   assign bus.illegal = illegal;
   assign bus.rd_data = is_csr && !illegal ? old_val : '0;
   assign bus.mtvec_o = mtvec_q;
   assign bus.mepc_o  = mepc_q;
   assign bus.mie_o   = mie_q;
   always_comb begin
      mie_d      = bus.trap_valid ? 1'b0 : bus.mret ? mpie_q : wa == A_MSTATUS ? new_val[3] : mie_q;
      mpie_d     = bus.trap_valid ? mie_q : bus.mret ? 1'b1 : wa == A_MSTATUS ? new_val[7] : mpie_q;
      mie_csr_d  = wa == A_MIE ? new_val : mie_csr_q;
      mtvec_d    = wa == A_MTVEC ? new_val & ALIGN : mtvec_q;
      mscratch_d = wa == A_MSCRATCH ? new_val : mscratch_q;
      mepc_d     = bus.trap_valid ? bus.trap_pc & ALIGN : wa == A_MEPC ? new_val & ALIGN : mepc_q;
      mcause_d   = bus.trap_valid ? bus.trap_cause : wa == A_MCAUSE ? new_val : mcause_q;
      mtval_d    = bus.trap_valid ? bus.trap_tval : wa == A_MTVAL ? new_val : mtval_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mie_csr_q  <= '0;
         mtvec_q    <= RESET_VEC & ALIGN;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mie_csr_q  <= mie_csr_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
`ifdef CSR_COUNTERS_EN
   logic [XLEN-1:0] cyc_q, cyc_d, ins_q, ins_d;
   // a CSR write replaces the increment for that cycle; traps never stall counting
   assign cyc_d = wa == A_MCYCLE ? new_val : cyc_q + XLEN'(1);
   assign ins_d = wa == A_MINSTRET ? new_val : ins_q + XLEN'(bus.retire);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ins_q <= ins_d;
      end
   assign cyc_rd = cyc_q;
   assign ins_rd = ins_q;
`else
   assign cyc_rd = '0;
   assign ins_rd = '0;
`endif
endmodule
